// File: rtl/rram_wv_16x16.sv
// rram_wv_16x16: behavioural RRAM macro model with write-verify programming.
// A read returns data after READ_LAT cycles. A write repeats verify and program
// pulses until the stored word matches the target or the pulse budget runs out.
// Each pulse flips at most BITS_PER_PULSE cells, lowest index first.
module rram_wv_16x16 #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int BITS_PER_PULSE = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int MAX_PULSES     = 8,
  parameter int READ_LAT       = 1
) (
  input  logic                              clk0,
  input  logic                              rst0,
  input  logic                              csb0,
  input  logic                              web0,
  input  logic [ADDR_WIDTH-1:0]             addr0,
  input  logic [DATA_WIDTH-1:0]             din0,
  input  logic [DATA_WIDTH-1:0]             inj_stuck0,
  output logic                              ready0,
  output logic [DATA_WIDTH-1:0]             dout0,
  output logic                              rvalid0,
  output logic                              wdone0,
  output logic                              wfail0,
  output logic [$clog2(MAX_PULSES+1)-1:0]   pulses0
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(MAX_PULSES + 1);
  localparam int LW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int PW    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PULSES);
  localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LAT - 1);
  localparam logic [PW-1:0] PULS_LAST = PW'(PULSE_CYCLES - 1);
  localparam int unsigned   BPP       = BITS_PER_PULSE;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    VERIFY,
    PULSE
  } state_t;

  state_t state, state_n;

  // Reset never touches the array. Power-up contents are zero in the
  // two-state simulators this model targets.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] target_q;
  logic [CW-1:0]         count;
  logic [LW-1:0]         lat_cnt;
  logic [PW-1:0]         pcyc_cnt;

  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] flippable;
  logic [DATA_WIDTH-1:0] flip_mask;
  int unsigned           flip_cnt;

  logic accept;
  logic rd_done;
  logic wr_done;
  logic wr_fail;
  logic flip_en;

  assign ready0    = (state == IDLE);
  assign diff      = mem[addr_q] ^ target_q;
  assign flippable = diff & ~inj_stuck0;

  // Select the lowest-index BITS_PER_PULSE set bits of the flippable cells
  always_comb begin
    flip_mask = '0;
    flip_cnt  = 0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (flippable[i] && (flip_cnt < BPP)) begin
        flip_mask[i] = 1'b1;
        flip_cnt     = flip_cnt + 1;
      end
    end
  end

  // Next-state logic and per-cycle strobes
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    wr_fail = 1'b0;
    flip_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (!csb0) begin
          accept  = 1'b1;
          state_n = web0 ? READ : VERIFY;
        end
      end
      READ: begin
        if (lat_cnt == LAT_LAST) begin
          rd_done = 1'b1;
          state_n = IDLE;
        end
      end
      VERIFY: begin
        if (diff == '0) begin
          wr_done = 1'b1;
          state_n = IDLE;
        end else if (count == MAX_CNT) begin
          wr_done = 1'b1;
          wr_fail = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (pcyc_cnt == PULS_LAST) begin
          flip_en = 1'b1;
          state_n = VERIFY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, captured request and registered outputs
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state    <= IDLE;
      rvalid0  <= 1'b0;
      wdone0   <= 1'b0;
      wfail0   <= 1'b0;
      pulses0  <= '0;
      dout0    <= '0;
      count    <= '0;
      lat_cnt  <= '0;
      pcyc_cnt <= '0;
    end else begin
      state   <= state_n;
      rvalid0 <= rd_done;
      wdone0  <= wr_done;
      wfail0  <= wr_fail;
      if (accept) begin
        addr_q   <= addr0;
        target_q <= din0;
        count    <= '0;
        lat_cnt  <= '0;
      end
      if (state == READ) lat_cnt <= lat_cnt + 1'b1;
      if (rd_done) dout0 <= mem[addr_q];
      if (wr_done) pulses0 <= count;
      if (state == VERIFY) pcyc_cnt <= '0;
      if (state == PULSE) pcyc_cnt <= pcyc_cnt + 1'b1;
      if (flip_en) count <= count + 1'b1;
    end
  end

  // Array update on the final edge of a pulse; a coinciding reset cancels it
  always_ff @(posedge clk0) begin
    if (!rst0 && flip_en) mem[addr_q] <= mem[addr_q] ^ flip_mask;
  end

endmodule

// File: tb/tb_rram_wv_16x16.sv
module tb_rram_wv_16x16;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int BPP = 4;
  localparam int PC  = 2;
  localparam int MP  = 8;
  localparam int RL  = 1;
  localparam int CW  = $clog2(MP + 1);

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] inj_stuck0;
  logic          ready0;
  logic [DW-1:0] dout0;
  logic          rvalid0;
  logic          wdone0;
  logic          wfail0;
  logic [CW-1:0] pulses0;

  rram_wv_16x16 #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BITS_PER_PULSE(BPP),
    .PULSE_CYCLES(PC), .MAX_PULSES(MP), .READ_LAT(RL)
  ) dut (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .addr0(addr0),
    .din0(din0), .inj_stuck0(inj_stuck0), .ready0(ready0), .dout0(dout0),
    .rvalid0(rvalid0), .wdone0(wdone0), .wfail0(wfail0), .pulses0(pulses0)
  );

  always #5 clk0 = ~clk0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [1 << AW];

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] s;
    int            lat;
    logic [DW-1:0] rdata;
    int            pulses;
    bit            fail;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  // Reference: program-and-verify with plain loops over the word
  function automatic int model_write(input int a, input logic [DW-1:0] tgt,
                                     input logic [DW-1:0] stuck, output bit fail);
    logic [DW-1:0] cur;
    logic [DW-1:0] fl;
    int k;
    int n;
    cur  = ref_mem[a];
    k    = 0;
    fail = 1'b0;
    while (cur != tgt) begin
      if (k == MP) begin
        fail = 1'b1;
        break;
      end
      fl = (cur ^ tgt) & ~stuck;
      n  = 0;
      for (int i = 0; i < DW; i++) begin
        if (fl[i] && n < BPP) begin
          cur[i] = ~cur[i];
          n++;
        end
      end
      k++;
    end
    ref_mem[a] = cur;
    return k;
  endfunction

  // Issue one request from idle and wait (bounded) for its completion pulse
  task automatic do_op(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] s, output int lat, output logic [1:0] kind,
                       output logic [DW-1:0] rd, output int pu, output bit fl,
                       output int busy_bad);
    busy_bad = 0;
    lat      = -1;
    kind     = 2'b00;
    csb0 = 1'b0; web0 = ~w; addr0 = a; din0 = d; inj_stuck0 = s;
    tick();
    csb0 = 1'b1; addr0 = AW'($urandom); din0 = DW'($urandom);
    for (int i = 1; i <= 200; i++) begin
      if (ready0) busy_bad++;
      tick();
      if (rvalid0 || wdone0) begin
        lat  = i;
        kind = {rvalid0, wdone0};
        break;
      end
    end
    rd = dout0;
    pu = int'(pulses0);
    fl = wfail0;
  endtask

  task automatic run_check(input string tag, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] s,
                           input int exp_lat, input logic [DW-1:0] exp_rd,
                           input int exp_pu, input bit exp_fl);
    int lat, pu, bb;
    logic [1:0] kind;
    logic [DW-1:0] rd;
    bit fl;
    chk({tag, "_ready_before"}, ready0, 1);
    do_op(w, a, d, s, lat, kind, rd, pu, fl, bb);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_kind"}, kind, w ? 2'b01 : 2'b10);
    chk({tag, "_busy_ready_low"}, bb, 0);
    if (w) begin
      chk({tag, "_pulses"}, pu, exp_pu);
      chk({tag, "_wfail"}, fl, exp_fl);
    end else begin
      chk({tag, "_dout"}, rd, exp_rd);
      chk({tag, "_wfail_rd"}, fl, 0);
    end
    chk({tag, "_ready_after"}, ready0, 1);
    tick();
    chk({tag, "_pulse_width"}, {rvalid0, wdone0, wfail0}, 3'b000);
  endtask

  initial begin
    int lat, k, seen;
    bit fl;
    logic [DW-1:0] d, s;
    logic [AW-1:0] a;

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

    // w, addr, data, stuck, latency, read data, pulses, fail
    tbl.push_back('{1'b1, 4'd3,  16'h00FF, 16'h0000, 7,  16'h0000, 2, 1'b0});
    tbl.push_back('{1'b0, 4'd3,  16'h0000, 16'h0000, 1,  16'h00FF, 0, 1'b0});
    tbl.push_back('{1'b1, 4'd3,  16'h00FF, 16'h0000, 1,  16'h0000, 0, 1'b0});
    tbl.push_back('{1'b0, 4'd3,  16'h0000, 16'h0000, 1,  16'h00FF, 0, 1'b0});
    tbl.push_back('{1'b1, 4'd5,  16'hFFFF, 16'h0001, 25, 16'h0000, 8, 1'b1});
    tbl.push_back('{1'b0, 4'd5,  16'h0000, 16'h0000, 1,  16'hFFFE, 0, 1'b0});
    tbl.push_back('{1'b1, 4'd0,  16'h1234, 16'h0000, 7,  16'h0000, 2, 1'b0});
    tbl.push_back('{1'b1, 4'd0,  16'h0000, 16'h0000, 7,  16'h0000, 2, 1'b0});
    tbl.push_back('{1'b0, 4'd0,  16'h0000, 16'h0000, 1,  16'h0000, 0, 1'b0});
    tbl.push_back('{1'b1, 4'd2,  16'h8001, 16'h8000, 25, 16'h0000, 8, 1'b1});
    tbl.push_back('{1'b0, 4'd2,  16'h0000, 16'h0000, 1,  16'h0001, 0, 1'b0});
    tbl.push_back('{1'b1, 4'd15, 16'hFFFF, 16'h0000, 13, 16'h0000, 4, 1'b0});
    tbl.push_back('{1'b0, 4'd15, 16'h0000, 16'h0000, 1,  16'hFFFF, 0, 1'b0});
    tbl.push_back('{1'b1, 4'd1,  16'h0003, 16'h0100, 4,  16'h0000, 1, 1'b0});
    tbl.push_back('{1'b0, 4'd1,  16'h0000, 16'h0000, 1,  16'h0003, 0, 1'b0});

    rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0; inj_stuck0 = '0;
    tick();
    tick();
    rst0 = 1'b0;
    chk("reset_ready", ready0, 1);
    chk("reset_rvalid", rvalid0, 0);
    chk("reset_wdone", wdone0, 0);
    chk("reset_wfail", wfail0, 0);
    chk("reset_pulses", pulses0, 0);
    chk("reset_dout", dout0, 0);

    foreach (tbl[i]) begin
      run_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s,
                tbl[i].lat, tbl[i].rdata, tbl[i].pulses, tbl[i].fail);
      if (tbl[i].w) k = model_write(int'(tbl[i].a), tbl[i].d, tbl[i].s, fl);
    end
    inj_stuck0 = '0;

    // Read request while a one-pulse write is busy is ignored, not queued
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd9; din0 = 16'h000F;
    tick();
    csb0 = 1'b1;
    tick();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
    tick();
    csb0 = 1'b1;
    lat = -1; seen = 0;
    for (int i = 3; i <= 60; i++) begin
      tick();
      if (rvalid0) seen++;
      if (wdone0) begin
        lat = i;
        break;
      end
    end
    chk("busy_write_latency", lat, 4);
    chk("busy_write_pulses", pulses0, 1);
    chk("busy_write_wfail", wfail0, 0);
    repeat (3) begin
      tick();
      if (rvalid0) seen++;
    end
    chk("busy_read_ignored", seen, 0);
    k = model_write(9, 16'h000F, 16'h0000, fl);
    run_check("busy_readback", 1'b0, 4'd9, '0, '0, 1, 16'h000F, 0, 1'b0);

    // Reset at edge T+5 of a write: first pulse kept, second cancelled
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd7; din0 = 16'hFFFF;
    tick();
    csb0 = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (wdone0) seen++;
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("midrst_ready", ready0, 1);
    chk("midrst_pulses", pulses0, 0);
    chk("midrst_dout", dout0, 0);
    repeat (30) begin
      if (wdone0 || rvalid0) seen++;
      tick();
    end
    chk("midrst_no_done", seen, 0);
    ref_mem[7] = 16'h000F;
    run_check("midrst_readback", 1'b0, 4'd7, '0, '0, 1, 16'h000F, 0, 1'b0);

    // Reset on the same edge as a read request drops the request
    rst0 = 1'b1; csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
    tick();
    rst0 = 1'b0; csb0 = 1'b1;
    chk("rstreq_ready", ready0, 1);
    chk("rstreq_outputs", {rvalid0, wdone0, wfail0}, 3'b000);
    chk("rstreq_dout", dout0, 0);
    tick();
    chk("rstreq_dropped", rvalid0, 0);
    chk("rstreq_ready_next", ready0, 1);

    // Randomised traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 2) == 0) begin
        run_check($sformatf("rnd%0d_rd", n), 1'b0, a, '0, '0, RL, ref_mem[a], 0, 1'b0);
      end else begin
        d = ($urandom_range(0, 4) == 0) ? ref_mem[a] : DW'($urandom);
        s = ($urandom_range(0, 3) == 0) ? DW'($urandom & $urandom & $urandom) : '0;
        k = model_write(int'(a), d, s, fl);
        run_check($sformatf("rnd%0d_wr", n), 1'b1, a, d, s, 1 + k * (PC + 1), '0, k, fl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
